// File: rtl/sobel_mag_thresh_if.sv
// Gradient-in / pixel-out stream bundle for sobel_mag_thresh.
// master = upstream driver and downstream sink, slave = the magnitude stage.
interface sobel_mag_thresh_if #(
    parameter int GRAD_WIDTH = 11
);
    logic                    vid_in_valid;
    logic [2*GRAD_WIDTH:0]   vid_in_data;
    logic [GRAD_WIDTH:0]     thresh;
    logic                    bin_mode;
    logic                    vid_out_valid;
    logic [7:0]              vid_out_data;
    logic                    vid_out_sof;
    logic                    vid_out_eol;

    modport master (
        output vid_in_valid, vid_in_data, thresh, bin_mode,
        input  vid_out_valid, vid_out_data, vid_out_sof, vid_out_eol
    );

    modport slave (
        input  vid_in_valid, vid_in_data, thresh, bin_mode,
        output vid_out_valid, vid_out_data, vid_out_sof, vid_out_eol
    );
endinterface

// File: rtl/sobel_mag_thresh.sv
// Sobel gradient magnitude |gx|+|gy| -> scaled 8-bit or binary edge pixel, with sof/eol framing.
// Optional per-frame edge statistics when SOBEL_MAG_STATS_EN is defined.
module sobel_mag_thresh #(
    parameter int VIDEO_WIDTH         = 1280,
    parameter int VIDEO_HEIGHT        = 960,
    parameter int GRAD_WIDTH          = 11,
    parameter int VIDEO_IN_DATA_WIDTH = 2*GRAD_WIDTH+1,
    parameter int MAG_WIDTH           = GRAD_WIDTH+1,
    parameter int MAG_SHIFT           = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    sobel_mag_thresh_if.slave vif
`ifdef SOBEL_MAG_STATS_EN
    ,
    output logic [31:0]       edge_count,
    output logic              edge_count_valid
`endif
);
    localparam int STAGES = 3;
    localparam int COL_W  = (VIDEO_WIDTH  > 1) ? $clog2(VIDEO_WIDTH)  : 1;
    localparam int ROW_W  = (VIDEO_HEIGHT > 1) ? $clog2(VIDEO_HEIGHT) : 1;

    // Per-pixel side band; the threshold/mode in effect travel with the pixel
    // so in-flight pixels of the old frame never see the new frame's shadow.
    typedef struct packed {
        logic                 sof;
        logic                 eol;
`ifdef SOBEL_MAG_STATS_EN
        logic                 last_row;
`endif
        logic                 border;
        logic                 bin;
        logic [MAG_WIDTH-1:0] thr;
    } tag_t;

    logic [STAGES:0]         vld_pipe;
    tag_t [STAGES-1:0]       tag_pipe;
    tag_t                    tag_in;

    logic [COL_W-1:0]        col_cnt;
    logic [ROW_W-1:0]        row_cnt;
    logic                    in_sof;
    logic                    in_eol;
    logic                    in_last_row;

    logic [MAG_WIDTH-1:0]    thr_shd;
    logic                    bin_shd;

    logic signed [GRAD_WIDTH-1:0] s0_gx;
    logic signed [GRAD_WIDTH-1:0] s0_gy;
    logic [GRAD_WIDTH-1:0]   s1_ax;
    logic [GRAD_WIDTH-1:0]   s1_ay;
    logic [MAG_WIDTH-1:0]    s2_mag;

    logic [MAG_WIDTH-1:0]    mag_sh;
    logic [7:0]              scaled;
    logic                    is_edge;
    logic [7:0]              out_nxt;

    logic [7:0]              out_data;
    logic                    out_sof;
    logic                    out_eol;

    // Negating the most-negative code yields its own bit pattern, which read
    // as unsigned is exactly 2^(GRAD_WIDTH-1): no overflow case to handle.
    function automatic logic [GRAD_WIDTH-1:0] abs_g(input logic signed [GRAD_WIDTH-1:0] v);
        return v[GRAD_WIDTH-1] ? ((~v) + {{(GRAD_WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign in_sof      = (col_cnt == '0) && (row_cnt == '0);
    assign in_eol      = (col_cnt == COL_W'(VIDEO_WIDTH-1));
    assign in_last_row = (row_cnt == ROW_W'(VIDEO_HEIGHT-1));

    always_comb begin
        tag_in          = '0;
        tag_in.sof      = in_sof;
        tag_in.eol      = in_eol;
`ifdef SOBEL_MAG_STATS_EN
        tag_in.last_row = in_last_row;
`endif
        tag_in.border   = vif.vid_in_data[0];
        tag_in.bin      = in_sof ? vif.bin_mode : bin_shd;
        tag_in.thr      = in_sof ? vif.thresh   : thr_shd;
    end

    // Frame position counters and shadow capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
            thr_shd <= '0;
            bin_shd <= 1'b0;
        end else if (vif.vid_in_valid) begin
            if (in_eol) begin
                col_cnt <= '0;
                row_cnt <= in_last_row ? '0 : row_cnt + ROW_W'(1);
            end else begin
                col_cnt <= col_cnt + COL_W'(1);
            end
            if (in_sof) begin
                thr_shd <= vif.thresh;
                bin_shd <= vif.bin_mode;
            end
        end
    end

    // Output stage decision from stage-2 magnitude
    assign mag_sh  = s2_mag >> MAG_SHIFT;
    assign scaled  = (mag_sh > MAG_WIDTH'(255)) ? 8'hFF : mag_sh[7:0];
    assign is_edge = (s2_mag >= tag_pipe[2].thr);

    always_comb begin
        out_nxt = 8'h00;
        if (!tag_pipe[2].border)
            out_nxt = tag_pipe[2].bin ? (is_edge ? 8'hFF : 8'h00) : scaled;
    end

    // Pipeline: s0 capture, s1 abs, s2 sum, s3 output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            s0_gx    <= '0;
            s0_gy    <= '0;
            s1_ax    <= '0;
            s1_ay    <= '0;
            s2_mag   <= '0;
            out_data <= '0;
            out_sof  <= 1'b0;
            out_eol  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], vif.vid_in_valid};
            tag_pipe <= {tag_pipe[STAGES-2:0], tag_in};
            s0_gx    <= vif.vid_in_data[VIDEO_IN_DATA_WIDTH-1 -: GRAD_WIDTH];
            s0_gy    <= vif.vid_in_data[GRAD_WIDTH:1];
            s1_ax    <= abs_g(s0_gx);
            s1_ay    <= abs_g(s0_gy);
            s2_mag   <= {1'b0, s1_ax} + {1'b0, s1_ay};
            out_data <= vld_pipe[2] ? out_nxt : 8'h00;
            out_sof  <= vld_pipe[2] && tag_pipe[2].sof;
            out_eol  <= vld_pipe[2] && tag_pipe[2].eol;
        end
    end

    assign vif.vid_out_valid = vld_pipe[STAGES];
    assign vif.vid_out_data  = out_data;
    assign vif.vid_out_sof   = out_sof;
    assign vif.vid_out_eol   = out_eol;

`ifdef SOBEL_MAG_STATS_EN
    logic        edge_hit;
    logic [31:0] edge_acc;

    assign edge_hit = vld_pipe[2] && tag_pipe[2].bin && !tag_pipe[2].border && is_edge;

    // Report lands on the same edge that emits the frame's final pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_acc         <= '0;
            edge_count       <= '0;
            edge_count_valid <= 1'b0;
        end else begin
            edge_count_valid <= 1'b0;
            if (vld_pipe[2] && tag_pipe[2].last_row && tag_pipe[2].eol) begin
                edge_count       <= edge_acc + 32'(edge_hit);
                edge_count_valid <= 1'b1;
                edge_acc         <= '0;
            end else if (edge_hit) begin
                edge_acc <= edge_acc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sobel_mag_thresh.sv
// Directed bench for sobel_mag_thresh on a reduced 8x3 frame; expected pixels are hand-computed.
// Stats checks compile in when SOBEL_MAG_STATS_EN is defined.
module tb_sobel_mag_thresh;
    localparam int W = 8;
    localparam int H = 3;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eol;
    } rec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   fails;
    int   pidx;
    rec_t exp_q[$];
    rec_t out_q[$];

    sobel_mag_thresh_if #(.GRAD_WIDTH(11)) vif ();

`ifdef SOBEL_MAG_STATS_EN
    logic [31:0] edge_count;
    logic        edge_count_valid;
    logic [31:0] ec_q[$];
`endif

    sobel_mag_thresh #(.VIDEO_WIDTH(W), .VIDEO_HEIGHT(H)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .vif              (vif)
`ifdef SOBEL_MAG_STATS_EN
        ,
        .edge_count       (edge_count),
        .edge_count_valid (edge_count_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output collector, sampled on the falling edge
    always @(negedge clk) begin
        rec_t r;
        if (vif.vid_out_valid) begin
            r.d   = vif.vid_out_data;
            r.sof = vif.vid_out_sof;
            r.eol = vif.vid_out_eol;
            out_q.push_back(r);
        end
`ifdef SOBEL_MAG_STATS_EN
        if (edge_count_valid) ec_q.push_back(edge_count);
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic px(input int gx, input int gy, input bit brd, input int exp_d);
        rec_t r;
        logic [10:0] gx_b;
        logic [10:0] gy_b;
        @(negedge clk);
        gx_b = 11'(gx);
        gy_b = 11'(gy);
        vif.vid_in_valid = 1'b1;
        vif.vid_in_data  = {gx_b, gy_b, brd};
        r.d   = 8'(exp_d);
        r.sof = ((pidx % (W*H)) == 0);
        r.eol = ((pidx % W) == W-1);
        exp_q.push_back(r);
        pidx++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vif.vid_in_valid = 1'b0;
        end
    endtask

    task automatic fill(input int n, input int exp_d);
        repeat (n) px(0, 0, 1'b0, exp_d);
    endtask

    // Drain the pipe, then compare collected outputs with expectations in order
    task automatic flush(input string name);
        int n;
        rec_t o;
        rec_t e;
        idle(6);
        chk({name, "_count"}, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            o = out_q[i];
            e = exp_q[i];
            chk($sformatf("%s_px%0d_data", name, i), o.d,   e.d);
            chk($sformatf("%s_px%0d_sof",  name, i), o.sof, e.sof);
            chk($sformatf("%s_px%0d_eol",  name, i), o.eol, e.eol);
        end
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        total = 0; passed = 0; fails = 0; pidx = 0;
        rst_n = 1'b0;
        vif.vid_in_valid = 1'b0;
        vif.vid_in_data  = '0;
        vif.thresh       = '0;
        vif.bin_mode     = 1'b0;

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_valid", vif.vid_out_valid, 0);
        chk("rst_data",  vif.vid_out_data,  0);
        chk("rst_sof",   vif.vid_out_sof,   0);
        chk("rst_eol",   vif.vid_out_eol,   0);
        rst_n = 1'b1;

        // Latency: 150 >> 3 = 18, three edges after capture
        px(100, -50, 1'b0, 18);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk($sformatf("lat_wait%0d", i), vif.vid_out_valid, 0);
        end
        idle(1);
        chk("lat_valid", vif.vid_out_valid, 1);
        chk("lat_data",  vif.vid_out_data,  18);
        chk("lat_sof",   vif.vid_out_sof,   1);
        chk("lat_eol",   vif.vid_out_eol,   0);

        // Frame A, scaled: extremes, rounding, border; mode change deferred
        px(-1024, -1024, 1'b0, 255);
        px(0, -1, 1'b0, 0);
        px(7, 8, 1'b0, 1);
        px(500, 500, 1'b1, 0);
        vif.bin_mode = 1'b1;
        vif.thresh   = 12'd200;
        px(300, 0, 1'b0, 37);
        px(0, 0, 1'b0, 0);
        px(-8, -8, 1'b0, 2);
        fill(16, 0);

        // Frame B, binary thr 200: 199/200/201, border, thresh change deferred
        px(100, -99, 1'b0, 0);
        px(-100, 100, 1'b0, 255);
        px(201, 0, 1'b0, 255);
        px(1000, 1000, 1'b1, 0);
        vif.thresh = 12'd1000;
        px(250, 250, 1'b0, 255);
        fill(19, 0);

        // Frame C, binary thr 1000 (inclusive)
        px(250, 250, 1'b0, 0);
        px(600, 400, 1'b0, 255);
        px(1023, 0, 1'b0, 255);
        vif.thresh = 12'd0;
        fill(21, 0);
        flush("abc");

        // Frame D, thr 0 with line gaps: all non-border pixels 255
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 1 && c == 3) px(-5, 9, 1'b1, 0);
                else                  px(c, -r, 1'b0, 255);
                if (c == 4) idle(1);
            end
            idle(3);
            if (r == 0) vif.thresh = 12'd4095;
        end

        // Frame E, thr 4095: nothing passes; stop at row H-1 col 5
        px(-1024, -1024, 1'b0, 0);
        px(1023, 1023, 1'b0, 0);
        fill(19, 0);
        flush("de");

        // Mid-line reset with last-line pixels in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vif.vid_in_valid = 1'b1;
            vif.vid_in_data  = {11'd1000, 11'd1000, 1'b0};
        end
        @(negedge clk);
        rst_n = 1'b0;
        vif.vid_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pidx = 0;
        vif.bin_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk($sformatf("post_rst_valid%0d", i), vif.vid_out_valid, 0);
        end
        px(16, 0, 1'b0, 2);
        flush("rst");

`ifdef SOBEL_MAG_STATS_EN
        chk("ec_pulses", ec_q.size(), 4);
        if (ec_q.size() == 4) begin
            chk("ec_frameA", ec_q[0], 0);
            chk("ec_frameB", ec_q[1], 3);
            chk("ec_frameC", ec_q[2], 2);
            chk("ec_frameD", ec_q[3], 23);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
